// File: rtl/vga_pkg.sv
// vga_pkg: shared SVGA 800x600 @ 60 Hz timing constants and counter width
package vga_pkg;
  localparam int VGA_CNT_W        = 11;
  localparam int VGA_H_ACTIVE     = 800;
  localparam int VGA_H_SYNC_START = 840;
  localparam int VGA_H_SYNC_END   = 967;
  localparam int VGA_H_TOTAL      = 1056;
  localparam int VGA_V_ACTIVE     = 600;
  localparam int VGA_V_SYNC_START = 601;
  localparam int VGA_V_SYNC_END   = 604;
  localparam int VGA_V_TOTAL      = 628;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator with registered counters, syncs, blanking and frame-start pulse
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_SYNC_START = VGA_H_SYNC_START,
  parameter int H_SYNC_END   = VGA_H_SYNC_END,
  parameter int H_TOTAL      = VGA_H_TOTAL,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_SYNC_START = VGA_V_SYNC_START,
  parameter int V_SYNC_END   = VGA_V_SYNC_END,
  parameter int V_TOTAL      = VGA_V_TOTAL
)(
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic [VGA_CNT_W-1:0] o_hcount,
  output logic                 o_hsync,
  output logic                 o_hblnk,
  output logic [VGA_CNT_W-1:0] o_vcount,
  output logic                 o_vsync,
  output logic                 o_vblnk,
  output logic                 o_frame_start
);
  localparam logic [VGA_CNT_W-1:0] HA  = VGA_CNT_W'(H_ACTIVE);
  localparam logic [VGA_CNT_W-1:0] HSS = VGA_CNT_W'(H_SYNC_START);
  localparam logic [VGA_CNT_W-1:0] HSE = VGA_CNT_W'(H_SYNC_END);
  localparam logic [VGA_CNT_W-1:0] HT1 = VGA_CNT_W'(H_TOTAL - 1);
  localparam logic [VGA_CNT_W-1:0] VA  = VGA_CNT_W'(V_ACTIVE);
  localparam logic [VGA_CNT_W-1:0] VSS = VGA_CNT_W'(V_SYNC_START);
  localparam logic [VGA_CNT_W-1:0] VSE = VGA_CNT_W'(V_SYNC_END);
  localparam logic [VGA_CNT_W-1:0] VT1 = VGA_CNT_W'(V_TOTAL - 1);
  localparam logic [VGA_CNT_W-1:0] ONE = VGA_CNT_W'(1);
  logic [VGA_CNT_W-1:0] r_hcount, r_vcount, w_h_next, w_v_next;
  logic                 r_hsync, r_hblnk, r_vsync, r_vblnk, r_frame_start, w_h_wrap;
  always_comb begin
    w_h_wrap = r_hcount == HT1;
    w_h_next = w_h_wrap ? '0 : r_hcount + ONE;
    w_v_next = !w_h_wrap ? r_vcount : (r_vcount == VT1) ? '0 : r_vcount + ONE;
  end
  // flags decode the next position so they land on the same edge as the counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= 1'b0;
      r_hblnk       <= 1'b0;
      r_vsync       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_frame_start <= 1'b1;
    end else begin
      r_hcount      <= w_h_next;
      r_vcount      <= w_v_next;
      r_hsync       <= (w_h_next >= HSS) && (w_h_next <= HSE);
      r_hblnk       <= w_h_next >= HA;
      r_vsync       <= (w_v_next >= VSS) && (w_v_next <= VSE);
      r_vblnk       <= w_v_next >= VA;
      r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
    end
  end
  assign o_hcount      = r_hcount;
  assign o_vcount      = r_vcount;
  assign o_hsync       = r_hsync;
  assign o_hblnk       = r_hblnk;
  assign o_vsync       = r_vsync;
  assign o_vblnk       = r_vblnk;
  assign o_frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: checks a default 800x600 instance and a scaled-down instance against a position model
module tb_vga_timing;
  localparam int SHA = 40, SHSS = 42, SHSE = 47, SHT = 52;
  localparam int SVA = 30, SVSS = 31, SVSE = 34, SVT = 38;
  localparam int SFRAME = SHT * SVT;
  logic clk = 1'b0, rst = 1'b1;
  logic [10:0] d_h, d_v, s_h, s_v;
  logic d_hs, d_hb, d_vs, d_vb, d_fs, s_hs, s_hb, s_vs, s_vb, s_fs;
  int total = 0, bad = 0, n = 0;
  logic valid = 1'b0;
  always #5 clk = ~clk;

  vga_timing dut_d (
    .i_clk(clk), .i_rst(rst), .o_hcount(d_h), .o_hsync(d_hs), .o_hblnk(d_hb),
    .o_vcount(d_v), .o_vsync(d_vs), .o_vblnk(d_vb), .o_frame_start(d_fs)
  );

  vga_timing #(
    .H_ACTIVE(SHA), .H_SYNC_START(SHSS), .H_SYNC_END(SHSE), .H_TOTAL(SHT),
    .V_ACTIVE(SVA), .V_SYNC_START(SVSS), .V_SYNC_END(SVSE), .V_TOTAL(SVT)
  ) dut_s (
    .i_clk(clk), .i_rst(rst), .o_hcount(s_h), .o_hsync(s_hs), .o_hblnk(s_hb),
    .o_vcount(s_v), .o_vsync(s_vs), .o_vblnk(s_vb), .o_frame_start(s_fs)
  );

  // model: n is the number of clock edges since the last edge that saw reset
  always @(posedge clk) begin
    n     <= rst ? 0 : n + 1;
    valid <= valid | rst;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=%0d want=%0d n=%0d", nm, act, exp, n);
    end
  endtask

  task automatic model_chk(input string nm, input int ha, input int hss, input int hse, input int ht,
                           input int va, input int vss, input int vse, input int vt,
                           input int h, input int v, input int hs, input int hb,
                           input int vs, input int vb, input int fs);
    int eh, ev;
    eh = n % ht;
    ev = (n / ht) % vt;
    chk({nm, ".hcount"}, h, eh);
    chk({nm, ".vcount"}, v, ev);
    chk({nm, ".hsync"}, hs, int'(eh >= hss && eh <= hse));
    chk({nm, ".hblnk"}, hb, int'(eh >= ha));
    chk({nm, ".vsync"}, vs, int'(ev >= vss && ev <= vse));
    chk({nm, ".vblnk"}, vb, int'(ev >= va));
    chk({nm, ".frame_start"}, fs, int'(eh == 0 && ev == 0));
  endtask

  always @(negedge clk) begin
    if (valid) begin
      model_chk("def", 800, 840, 967, 1056, 600, 601, 604, 628,
                d_h, d_v, d_hs, d_hb, d_vs, d_vb, d_fs);
      model_chk("small", SHA, SHSS, SHSE, SHT, SVA, SVSS, SVSE, SVT,
                s_h, s_v, s_hs, s_hb, s_vs, s_vb, s_fs);
    end
  end

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (n != target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (n != target) begin
      $display("FAIL run_to got=%0d want=%0d", n, target);
      bad++;
    end
  endtask

  task automatic gap_to_fs(input string nm, input int exp);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!s_fs && c < 5000);
    chk(nm, c, exp);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst.hcount", d_h, 0);
    chk("rst.vcount", d_v, 0);
    chk("rst.flags", {d_hs, d_hb, d_vs, d_vb}, 0);
    chk("rst.frame_start", d_fs, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rel.hcount", d_h, 1);
    chk("rel.vcount", d_v, 0);
    chk("rel.frame_start", d_fs, 0);
    run_to(799);  chk("hblnk@799", d_hb, 0);
    run_to(800);  chk("hblnk@800", d_hb, 1);
    run_to(839);  chk("hsync@839", d_hs, 0);
    run_to(840);  chk("hsync@840", d_hs, 1);
    chk("hcount@840", d_h, 840);
    run_to(967);  chk("hsync@967", d_hs, 1);
    run_to(968);  chk("hsync@968", d_hs, 0);
    run_to(1055); chk("h_end.hcount", d_h, 1055);
    chk("h_end.vcount", d_v, 0);
    run_to(1056); chk("h_wrap.hcount", d_h, 0);
    chk("h_wrap.vcount", d_v, 1);
    chk("h_wrap.hblnk", d_hb, 0);
    run_to(1611); chk("s.vsync@30", s_vs, 0);
    chk("s.vblnk@30", s_vb, 1);
    run_to(1612); chk("s.vsync@31", s_vs, 1);
    chk("s.hcount@31", s_h, 0);
    run_to(SFRAME - 1);
    chk("s.eof.hcount", s_h, 51);
    chk("s.eof.vcount", s_v, 37);
    run_to(SFRAME);
    chk("s.sof.pos", {s_h, s_v}, 0);
    chk("s.sof.frame_start", s_fs, 1);
    chk("s.sof.blnk", {s_hb, s_vb}, 0);
    gap_to_fs("s.frame_period", 1976);
    run_to(2 * SFRAME + 17 * SHT + 12);
    chk("s.mid.hcount", s_h, 12);
    chk("s.mid.vcount", s_v, 17);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst.pos", {s_h, s_v, d_h, d_v}, 0);
    chk("mid_rst.frame_start", {s_fs, d_fs}, 3);
    @(negedge clk);
    chk("mid_rst.resume", s_h, 1);
    gap_to_fs("s.after_rst_period", 1975);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
